axi_rd_beat_sequencer: RTL and testbench

Responder-side AXI read address sequencer. Accepts one AR burst request and expands it into a stream of per-beat addresses, one per handshake, with a last-beat flag and pass-through ID. Sits between the slave AR channel and the memory/read-data path of AXI slaves; it is the per-beat consumer of the same burst addressing rules that initiators use to generate bursts.

---
 rtl/axi_rd_beat_sequencer.sv | 125 ++++++++++++
 tb/tb_axi_rd_beat_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_beat_sequencer.sv
// Responder-side AXI read address sequencer: expands one AR burst into per-beat
// addresses (FIXED / INCR / WRAP) with last flag and pass-through ID.
module axi_rd_beat_sequencer #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32,
    parameter int unsigned IW = 2
) (
    input  logic          S_AXI_ACLK,
    input  logic          S_AXI_ARESETN,
    input  logic          S_AXI_ARVALID,
    output logic          S_AXI_ARREADY,
    input  logic [IW-1:0] S_AXI_ARID,
    input  logic [AW-1:0] S_AXI_ARADDR,
    input  logic [7:0]    S_AXI_ARLEN,
    input  logic [2:0]    S_AXI_ARSIZE,
    input  logic [1:0]    S_AXI_ARBURST,
    output logic          o_beat_valid,
    input  logic          i_beat_ready,
    output logic [AW-1:0] o_beat_addr,
    output logic [IW-1:0] o_beat_id,
    output logic [2:0]    o_beat_size,
    output logic          o_beat_last
);
    localparam int unsigned DSZ = $clog2(DW) - 3;
    localparam int unsigned LW  = (AW < 12) ? AW : 12;

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state_q;
    logic          arready_q, valid_q, fixed_q, wrap_q;
    logic [7:0]    cnt_q;
    logic [AW-1:0] addr_q, addr_d;
    logic [IW-1:0] id_q;
    logic [2:0]    size_q;
    logic [LW-1:0] mask_q;

    logic [2:0]    ar_size_c;
    logic          wrap_ok_c;
    logic [11:0]   span_c;
    logic [LW-1:0] mask_c, incr_c, lo_c, sum_c;

    // Request decode: clamped size, WRAP legality and wrap mask
    always_comb begin
        ar_size_c = (S_AXI_ARSIZE > 3'(DSZ)) ? 3'(DSZ) : S_AXI_ARSIZE;
        wrap_ok_c = (S_AXI_ARBURST == 2'b10) &&
                    ((S_AXI_ARLEN == 8'd1) || (S_AXI_ARLEN == 8'd3) ||
                     (S_AXI_ARLEN == 8'd7) || (S_AXI_ARLEN == 8'd15));
        span_c    = (12'(S_AXI_ARLEN[3:0]) + 12'd1) << ar_size_c;
        mask_c    = LW'(span_c - 12'd1);
    end

    // Increment picked from the legal sizes only, so no oversized shifts appear
    always_comb begin
        incr_c = '0;
        for (int s = 0; s <= int'(DSZ); s++) begin
            if (size_q == 3'(s)) incr_c = LW'(1) << s;
        end
    end

    // Next beat address; only the in-page low bits ever move
    always_comb begin
        lo_c   = addr_q[LW-1:0];
        sum_c  = (lo_c & ~(incr_c - LW'(1))) + incr_c;
        addr_d = addr_q;
        if (wrap_q) begin
            addr_d[LW-1:0] = (lo_c & ~mask_q) | (sum_c & mask_q);
        end else if (!fixed_q) begin
            addr_d[LW-1:0] = sum_c;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q   <= IDLE;
            arready_q <= 1'b0;
            valid_q   <= 1'b0;
            fixed_q   <= 1'b0;
            wrap_q    <= 1'b0;
            cnt_q     <= '0;
            addr_q    <= '0;
            id_q      <= '0;
            size_q    <= '0;
            mask_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    arready_q <= 1'b1;
                    if (S_AXI_ARVALID && arready_q) begin
                        state_q   <= BURST;
                        arready_q <= 1'b0;
                        valid_q   <= 1'b1;
                        id_q      <= S_AXI_ARID;
                        addr_q    <= S_AXI_ARADDR;
                        size_q    <= ar_size_c;
                        fixed_q   <= (S_AXI_ARBURST == 2'b00);
                        wrap_q    <= wrap_ok_c;
                        mask_q    <= mask_c;
                        cnt_q     <= S_AXI_ARLEN;
                    end
                end
                BURST: begin
                    if (i_beat_ready) begin
                        if (cnt_q == 8'd0) begin
                            state_q   <= IDLE;
                            valid_q   <= 1'b0;
                            arready_q <= 1'b1;
                        end else begin
                            cnt_q  <= cnt_q - 8'd1;
                            addr_q <= addr_d;
                        end
                    end
                end
            endcase
        end
    end

    assign S_AXI_ARREADY = arready_q;
    assign o_beat_valid  = valid_q;
    assign o_beat_addr   = addr_q;
    assign o_beat_id     = id_q;
    assign o_beat_size   = size_q;
    // Gated by valid so last reads 0 in reset and between bursts
    assign o_beat_last   = valid_q && (cnt_q == 8'd0);

endmodule

// File: tb/tb_axi_rd_beat_sequencer.sv
// Bench for axi_rd_beat_sequencer: directed bursts, expected beats from a
// closed-form burst address model, checked every cycle by one compare process.
module tb_axi_rd_beat_sequencer;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int IW  = 2;
    localparam int DSZ = $clog2(DW) - 3;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  id;
        logic [2:0]  size;
        logic        last;
    } beat_t;

    logic          clk, rst_n;
    logic          arvalid, arready;
    logic [IW-1:0] arid;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          o_beat_valid, i_beat_ready, o_beat_last;
    logic [AW-1:0] o_beat_addr;
    logic [IW-1:0] o_beat_id;
    logic [2:0]    o_beat_size;

    int    n_vec = 0;
    int    n_err = 0;
    beat_t exp_q[$];
    bit    ar_prev = 0;
    bit    last_prev = 0;

    axi_rd_beat_sequencer #(.AW(AW), .DW(DW), .IW(IW)) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_ARID    (arid),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARLEN   (arlen),
        .S_AXI_ARSIZE  (arsize),
        .S_AXI_ARBURST (arburst),
        .o_beat_valid  (o_beat_valid),
        .i_beat_ready  (i_beat_ready),
        .o_beat_addr   (o_beat_addr),
        .o_beat_id     (o_beat_id),
        .o_beat_size   (o_beat_size),
        .o_beat_last   (o_beat_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int eff_size(input int size);
        return (size > DSZ) ? DSZ : size;
    endfunction

    // Closed-form address of beat k of a burst
    function automatic logic [31:0] model_addr(input logic [31:0] a, input int len,
                                               input int size, input logic [1:0] bt, input int k);
        int          incr;
        int          nb;
        logic [31:0] al;
        logic [31:0] base;
        incr = 1 << eff_size(size);
        if (k == 0 || bt == 2'b00) return a;
        al = a & ~32'(incr - 1);
        if (bt == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            nb   = (len + 1) * incr;
            base = al & ~32'(nb - 1);
            return base + ((al - base + 32'(k * incr)) % 32'(nb));
        end
        return (a & ~32'hFFF) | ((al + 32'(k * incr)) & 32'hFFF);
    endfunction

    // Per-cycle compare against the expected-beat queue
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_valid", 32'(o_beat_valid), 32'd0);
            chk("rst_arready", 32'(arready), 32'd0);
            chk("rst_last", 32'(o_beat_last), 32'd0);
            chk("rst_addr", 32'(o_beat_addr), 32'd0);
            chk("rst_id", 32'(o_beat_id), 32'd0);
            chk("rst_size", 32'(o_beat_size), 32'd0);
            exp_q.delete();
            ar_prev   = 0;
            last_prev = 0;
        end else begin
            if (ar_prev) chk("ar_to_first_beat", 32'(o_beat_valid), 32'd1);
            if (last_prev) begin
                chk("after_last_valid", 32'(o_beat_valid), 32'd0);
                chk("after_last_arready", 32'(arready), 32'd1);
            end
            if (o_beat_valid) begin
                chk("busy_arready", 32'(arready), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("stale_beat_valid", 32'(o_beat_valid), 32'd0);
                end else begin
                    chk("beat_addr", 32'(o_beat_addr), exp_q[0].addr);
                    chk("beat_id", 32'(o_beat_id), 32'(exp_q[0].id));
                    chk("beat_size", 32'(o_beat_size), 32'(exp_q[0].size));
                    chk("beat_last", 32'(o_beat_last), 32'(exp_q[0].last));
                end
            end
            ar_prev   = arvalid && arready;
            last_prev = o_beat_valid && i_beat_ready && o_beat_last;
            if (o_beat_valid && i_beat_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        end
    end

    task automatic run_burst(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                             input logic [1:0] bt, input logic [1:0] id,
                             input int stall_at, input int stall_n, input bit drain);
        bit    hs;
        beat_t b;
        @(posedge clk); #1;
        arvalid = 1'b1; araddr = a; arlen = len; arsize = sz; arburst = bt; arid = id;
        hs = 0;
        for (int t = 0; t < 60 && !hs; t++) begin
            @(negedge clk);
            hs = arready;
            @(posedge clk); #1;
        end
        arvalid = 1'b0;
        araddr  = 32'hDEAD_BEEF;
        if (!hs) begin
            chk("ar_handshake_timeout", 32'd0, 32'd1);
            return;
        end
        for (int k = 0; k <= int'(len); k++) begin
            b.addr = model_addr(a, int'(len), int'(sz), bt, k);
            b.id   = id;
            b.size = 3'(eff_size(int'(sz)));
            b.last = (k == int'(len));
            exp_q.push_back(b);
        end
        if (drain) begin
            for (int c = 0; c < 300 && exp_q.size() > 0; c++) begin
                i_beat_ready = !(c >= stall_at && c < stall_at + stall_n);
                @(posedge clk); #1;
            end
            i_beat_ready = 1'b1;
            chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; arvalid = 1'b0; arid = '0; araddr = '0; arlen = '0;
        arsize = '0; arburst = '0; i_beat_ready = 1'b1;

        // Hand-computed values pinning the model
        chk("model_incr_b3", model_addr(32'h1000, 3, 2, 2'b01, 3), 32'h0000_100C);
        chk("model_unal_b1", model_addr(32'h1003, 2, 2, 2'b01, 1), 32'h0000_1004);
        chk("model_wrap_b2", model_addr(32'h2008, 3, 2, 2'b10, 2), 32'h0000_2000);
        chk("model_wrapinc", model_addr(32'h2008, 2, 2, 2'b10, 2), 32'h0000_2010);
        chk("model_fixed", model_addr(32'h0030, 2, 2, 2'b00, 2), 32'h0000_0030);
        chk("model_page", model_addr(32'h1FFC, 1, 2, 2'b01, 1), 32'h0000_1000);
        chk("model_clamp", model_addr(32'h0040, 1, 3, 2'b01, 1), 32'h0000_0044);
        chk("model_wrap8", model_addr(32'h0105, 7, 0, 2'b10, 3), 32'h0000_0100);
        chk("model_size", 32'(eff_size(3)), 32'd2);

        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("arready_before_edge", 32'(arready), 32'd0);
        @(posedge clk); #1;
        chk("arready_after_release", 32'(arready), 32'd1);

        run_burst(32'h1000, 8'd3, 3'd2, 2'b01, 2'd1, 0, 0, 1);
        run_burst(32'h1003, 8'd2, 3'd2, 2'b01, 2'd2, 0, 0, 1);
        run_burst(32'h2008, 8'd3, 3'd2, 2'b10, 2'd3, 0, 0, 1);
        run_burst(32'h2008, 8'd2, 3'd2, 2'b10, 2'd0, 0, 0, 1);
        run_burst(32'h0030, 8'd2, 3'd2, 2'b00, 2'd1, 0, 0, 1);
        run_burst(32'h1FFC, 8'd1, 3'd2, 2'b01, 2'd2, 0, 0, 1);
        run_burst(32'h0040, 8'd1, 3'd3, 2'b01, 2'd3, 0, 0, 1);
        run_burst(32'h0500, 8'd2, 3'd1, 2'b11, 2'd0, 0, 0, 1);
        run_burst(32'h4000, 8'd5, 3'd2, 2'b01, 2'd1, 2, 3, 1);
        run_burst(32'h0105, 8'd7, 3'd0, 2'b10, 2'd2, 1, 2, 1);
        // Back-to-back: second request is held while the first is in flight
        run_burst(32'h0600, 8'd0, 3'd0, 2'b01, 2'd3, 0, 0, 0);
        run_burst(32'h003C, 8'd1, 3'd2, 2'b10, 2'd1, 0, 0, 1);
        run_burst(32'h7004, 8'd4, 3'd2, 2'b01, 2'd2, 0, 0, 0);
        run_burst(32'h8000, 8'd1, 3'd1, 2'b01, 2'd0, 0, 0, 1);

        // Reset pulse mid-burst discards the remaining beats
        run_burst(32'h5000, 8'd7, 3'd2, 2'b01, 2'd3, 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(o_beat_valid), 32'd0);
        chk("midrst_arready", 32'(arready), 32'd0);
        chk("midrst_last", 32'(o_beat_last), 32'd0);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_arready_pre", 32'(arready), 32'd0);
        @(posedge clk); #1;
        chk("midrst_arready_post", 32'(arready), 32'd1);
        chk("midrst_no_beat", 32'(o_beat_valid), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        run_burst(32'h0ABC, 8'd2, 3'd2, 2'b01, 2'd1, 0, 0, 1);
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
